// File: rtl/seq_nr_divider_if.sv
// Start/done handshake and operand/result bus for the sequential divider.
// The master side issues divide requests; the slave side is the divider itself.
interface seq_nr_divider_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_zero
  );

endinterface

// File: rtl/seq_nr_divider.sv
// Sequential unsigned non-restoring divider.
// A single WIDTH+1-bit controlled add/subtract row is reused once per cycle:
// WIDTH RUN steps, one FIX step for the final remainder correction, then a
// one-cycle DONE pulse. Division by zero bypasses the datapath and finishes
// in a single cycle with quotient = all ones and remainder = dividend.
module seq_nr_divider #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_nr_divider_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH:0]   partRem_q,   partRem_d;
  logic [WIDTH-1:0] quoShift_q,  quoShift_d;
  logic [WIDTH:0]   divisor_q,   divisor_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             divZero_q,   divZero_d;

  logic [WIDTH:0]   shiftRem;
  logic [WIDTH:0]   casA;
  logic             casP;
  logic [WIDTH:0]   casSum;
  logic [WIDTH:0]   fixedRem;
  logic             lastStep;

  // Partial remainder after the {R,Q} left shift: the quotient MSB enters R.
  assign shiftRem = {partRem_q[WIDTH-1:0], quoShift_q[WIDTH-1]};
  assign lastStep = (cnt_q == CW'(WIDTH - 1));

  // The one CAS row: RUN feeds the shifted remainder with P from the sign,
  // FIX reuses the same adder as a plain R + D for the correction.
  always_comb begin
    casA = shiftRem;
    casP = ~partRem_q[WIDTH];
    if (state_q == FIX) begin
      casA = partRem_q;
      casP = 1'b0;
    end
    casSum = casA + (divisor_q ^ {(WIDTH + 1){casP}}) + {{WIDTH{1'b0}}, casP};
  end

  // A negative final remainder gets the divisor added back.
  assign fixedRem = partRem_q[WIDTH] ? casSum : partRem_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      partRem_q   <= '0;
      quoShift_q  <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divZero_q   <= 1'b0;
    end else begin
      partRem_q   <= partRem_d;
      quoShift_q  <= quoShift_d;
      divisor_q   <= divisor_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      divZero_q   <= divZero_d;
    end
  end

  // Next-state and datapath update; results only change on entry to DONE.
  always_comb begin
    state_d     = state_q;
    partRem_d   = partRem_q;
    quoShift_d  = quoShift_q;
    divisor_d   = divisor_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    divZero_d   = divZero_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          if (bus.divisor != '0) begin
            partRem_d  = '0;
            quoShift_d = bus.dividend;
            divisor_d  = {1'b0, bus.divisor};
            cnt_d      = '0;
            state_d    = RUN;
          end else begin
            quotient_d  = '1;
            remainder_d = bus.dividend;
            divZero_d   = 1'b1;
            state_d     = DONE;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        partRem_d  = casSum;
        quoShift_d = {quoShift_q[WIDTH-2:0], ~casSum[WIDTH]};
        cnt_d      = cnt_q + CW'(1);
        if (lastStep) begin
          state_d = FIX;
        end
      end

      FIX: begin
        partRem_d   = fixedRem;
        quotient_d  = quoShift_q;
        remainder_d = fixedRem[WIDTH-1:0];
        divZero_d   = 1'b0;
        state_d     = DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy      = (state_q == RUN) || (state_q == FIX);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = divZero_q;

endmodule
